// File: rtl/multichan_deframer.sv
// Receive-side deframer for the multi-channel packet link: HEAD/CHANNEL/LENGTH/DATA/END -> message port.
// Optional drop_count statistics port is enabled by defining MULTICHAN_DEFRAMER_STATS_EN.
module multichan_deframer #(
  parameter int unsigned PACKET_SIZE = 8,
  parameter int unsigned MESSAGE_BIT = 256,
  parameter int unsigned CHANNEL_BIT = 1
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   in_valid,
  input  logic [PACKET_SIZE-1:0] in_data,
  output logic                   in_ready,
  output logic                   msg_valid,
  input  logic                   msg_ready,
  output logic [CHANNEL_BIT-1:0] msg_channel,
  output logic [4:0]             msg_length,
  output logic [MESSAGE_BIT-1:0] msg_data
`ifdef MULTICHAN_DEFRAMER_STATS_EN
  ,
  output logic [15:0]            drop_count
`endif
);

  localparam int unsigned PAY = PACKET_SIZE - 1;

  typedef logic [MESSAGE_BIT-1:0] msg_t;
  typedef enum logic [2:0] {S_IDLE, S_CHAN, S_LEN, S_DATA, S_END} state_t;

  state_t               state;
  logic [4:0]           id;
  logic [CHANNEL_BIT-1:0] chan;
  logic [4:0]           len;
  logic [9:0]           bit_cnt;
  msg_t                 assy;

  logic [2:0] tag;
  logic       is_data, is_head, is_chan, is_len, is_end;
  logic       accept, oversize, data_done, id_match;
  logic [4:0] field;
  logic [9:0] next_cnt;
  msg_t       shifted, keep;

  assign tag      = in_data[PACKET_SIZE-1 -: 3];
  assign is_data  = ~in_data[PACKET_SIZE-1];
  assign is_head  = (tag == 3'b100);
  assign is_chan  = (tag == 3'b101);
  assign is_len   = (tag == 3'b110);
  assign is_end   = (tag == 3'b111);
  assign field    = in_data[4:0];
  assign id_match = (field == id);

  assign in_ready = ~((state == S_END) && msg_valid && ~msg_ready);
  assign accept   = in_valid && in_ready;

  assign oversize  = {27'd0, field} > 32'(MESSAGE_BIT / 8);
  assign next_cnt  = bit_cnt + 10'(PAY);
  assign data_done = next_cnt >= {2'b00, len, 3'b000};
  // Payload bits shifted past MESSAGE_BIT fall off the top of the assembly register.
  assign shifted   = msg_t'(in_data[PAY-1:0]) << bit_cnt;
  assign keep      = ~(msg_t'('1) << {len, 3'b000});

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      id          <= '0;
      chan        <= '0;
      len         <= '0;
      bit_cnt     <= '0;
      assy        <= '0;
      msg_valid   <= 1'b0;
      msg_channel <= '0;
      msg_length  <= '0;
      msg_data    <= '0;
    end else begin
      if (msg_valid && msg_ready) msg_valid <= 1'b0;
      if (accept) begin
        if (is_head) begin
          id      <= field;
          bit_cnt <= '0;
          assy    <= '0;
          state   <= S_CHAN;
        end else begin
          unique case (state)
            S_IDLE: state <= S_IDLE;
            S_CHAN: begin
              if (is_chan) begin
                chan  <= in_data[CHANNEL_BIT-1:0];
                state <= S_LEN;
              end else state <= S_IDLE;
            end
            S_LEN: begin
              if (is_len) begin
                len <= field;
                if (field == 5'd0)  state <= S_END;
                else if (oversize)  state <= S_IDLE;
                else                state <= S_DATA;
              end else state <= S_IDLE;
            end
            S_DATA: begin
              if (is_data) begin
                assy    <= assy | shifted;
                bit_cnt <= next_cnt;
                if (data_done) state <= S_END;
              end else state <= S_IDLE;
            end
            S_END: begin
              // A load here may coincide with the previous message's handshake; the load wins.
              if (is_end && id_match) begin
                msg_data    <= assy & keep;
                msg_channel <= chan;
                msg_length  <= len;
                msg_valid   <= 1'b1;
              end
              state <= S_IDLE;
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

`ifdef MULTICHAN_DEFRAMER_STATS_EN
  logic drop;

  always_comb begin
    drop = 1'b0;
    if (accept) begin
      unique case (state)
        S_CHAN:  drop = ~is_chan;
        S_LEN:   drop = ~is_len | oversize;
        S_DATA:  drop = ~is_data;
        S_END:   drop = ~(is_end && id_match);
        default: drop = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) drop_count <= '0;
    else if (drop && (drop_count != '1)) drop_count <= drop_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_multichan_deframer.sv
// Scoreboard bench for multichan_deframer: frame-level reference model feeds an expected-message queue.
module tb_multichan_deframer;
  localparam int PS = 8;
  localparam int MB = 32;
  localparam int CB = 1;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          in_valid = 1'b0;
  logic [PS-1:0] in_data = '0;
  logic          in_ready;
  logic          msg_valid;
  logic          msg_ready = 1'b0;
  logic [CB-1:0] msg_channel;
  logic [4:0]    msg_length;
  logic [MB-1:0] msg_data;
`ifdef MULTICHAN_DEFRAMER_STATS_EN
  logic [15:0]   drop_count;
`endif

  multichan_deframer #(.PACKET_SIZE(PS), .MESSAGE_BIT(MB), .CHANNEL_BIT(CB)) dut (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_channel(msg_channel),
    .msg_length(msg_length), .msg_data(msg_data)
`ifdef MULTICHAN_DEFRAMER_STATS_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;  // 0: hold low, 1: hold high, 2: random

  typedef struct {
    logic [CB-1:0] ch;
    logic [4:0]    len;
    logic [MB-1:0] data;
  } exp_t;
  exp_t expq[$];

  // Frame-level reference: tracks which field a frame still needs, not the DUT's states.
  bit          m_in_frame, m_have_ch, m_have_len;
  int          m_need, m_ndata, m_drops;
  logic [4:0]  m_id, m_len;
  logic [CB-1:0] m_ch;
  logic [63:0] m_acc;

  function automatic void model_reset();
    m_in_frame = 0; m_have_ch = 0; m_have_len = 0;
    m_need = 0; m_ndata = 0; m_drops = 0; m_acc = '0;
  endfunction

  function automatic void model_abandon();
    m_drops++;
    m_in_frame = 0;
  endfunction

  function automatic void model_word(input logic [7:0] w);
    logic [2:0] tag;
    exp_t e;
    tag = w[7:5];
    if (tag == 3'b100) begin
      if (m_in_frame) m_drops++;
      m_in_frame = 1; m_have_ch = 0; m_have_len = 0;
      m_ndata = 0; m_acc = '0; m_id = w[4:0];
      return;
    end
    if (!m_in_frame) return;
    if (!m_have_ch) begin
      if (tag == 3'b101) begin m_ch = w[CB-1:0]; m_have_ch = 1; end
      else model_abandon();
    end else if (!m_have_len) begin
      if (tag == 3'b110) begin
        m_len = w[4:0];
        m_have_len = 1;
        m_need = (int'(m_len) * 8 + 6) / 7;
        if (int'(m_len) > MB / 8) model_abandon();
      end else model_abandon();
    end else if (m_ndata < m_need) begin
      if (!w[7]) begin
        m_acc = m_acc | (64'(w[6:0]) << (7 * m_ndata));
        m_ndata++;
      end else model_abandon();
    end else begin
      if (tag == 3'b111 && w[4:0] == m_id) begin
        e.ch   = m_ch;
        e.len  = m_len;
        e.data = MB'(m_acc & ((64'd1 << (int'(m_len) * 8)) - 64'd1));
        expq.push_back(e);
        m_in_frame = 0;
      end else model_abandon();
    end
  endfunction

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      case (rdy_mode)
        0:       msg_ready = 1'b0;
        1:       msg_ready = 1'b1;
        default: msg_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST_N && msg_valid && msg_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_msg got ch=%0h len=%0d data=%h, none expected",
                   msg_channel, msg_length, msg_data);
        end else begin
          e = expq.pop_front();
          if (msg_channel !== e.ch || msg_length !== e.len || msg_data !== e.data) begin
            errors++;
            $display("FAIL msg got ch=%0h len=%0d data=%h expected ch=%0h len=%0d data=%h",
                     msg_channel, msg_length, msg_data, e.ch, e.len, e.data);
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] w);
    bit acc;
    acc = 0;
    in_data  = w;
    in_valid = 1'b1;
    for (int c = 0; c < 200 && !acc; c++) begin
      @(negedge CLK);
      acc = in_ready;
      @(posedge CLK);
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept word=%h in_ready=0 for 200 cycles, expected acceptance", w);
    end else model_word(w);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_list(input logic [7:0] ws[$]);
    foreach (ws[i]) send(ws[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check_drops(input string name);
`ifdef MULTICHAN_DEFRAMER_STATS_EN
    checks++;
    if (drop_count !== 16'(m_drops)) begin
      errors++;
      $display("FAIL drops_%s got %0d expected %0d", name, drop_count, m_drops);
    end
`endif
  endtask

  task automatic check_drained(input string name);
    rdy_mode = 1;
    idle(8);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drained_%s got %0d undelivered messages expected 0", name, expq.size());
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (msg_valid !== 1'b0 || msg_channel !== '0 || msg_length !== 5'd0 ||
        msg_data !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_%s got valid=%b ch=%0h len=%0d data=%h ready=%b expected 0/0/0/0/1",
               name, msg_valid, msg_channel, msg_length, msg_data, in_ready);
    end
  endtask

  task automatic rand_frame();
    logic [7:0] ws[$];
    logic [7:0] w;
    logic [4:0] id, len;
    int nd;
    id  = 5'($urandom_range(0, 31));
    len = 5'($urandom_range(0, 5));
    nd  = (int'(len) * 8 + 6) / 7;
    ws.push_back({3'b100, id});
    ws.push_back({3'b101, 4'($urandom), 1'($urandom)});
    ws.push_back({3'b110, len});
    for (int i = 0; i < nd; i++) ws.push_back({1'b0, 7'($urandom)});
    if ($urandom_range(0, 9) < 8) ws.push_back({3'b111, id});
    else ws.push_back({3'b111, 5'($urandom)});
    if ($urandom_range(0, 9) == 0) ws[$urandom_range(0, ws.size() - 1)] = 8'($urandom);
    if ($urandom_range(0, 19) == 0) ws.insert($urandom_range(0, ws.size()), 8'($urandom));
    foreach (ws[i]) begin
      w = ws[i];
      send(w);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    logic [7:0] good[$];
    good = '{8'h81, 8'hA1, 8'hC4, 8'h6F, 8'h7D, 8'h36, 8'h75, 8'h0D, 8'hE1};
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("initial");
    RST_N = 1'b1;
    rdy_mode = 1;
    idle(2);

    send_list(good);
    idle(3);
    check_drops("good");

    // Length 1 needs ceil(8/7) = 2 data words.
    send_list('{8'h82, 8'hA0, 8'hC1, 8'h55, 8'h00, 8'hE2});
    idle(3);

    send_list('{8'h81, 8'hA1, 8'hC4, 8'h6F, 8'h7D, 8'h36, 8'h75, 8'h0D, 8'hE2});
    idle(3);
    check_drops("id_mismatch");

    send_list('{8'h81, 8'hA1, 8'h83, 8'hA0, 8'hC1, 8'h12, 8'h00, 8'hE3});
    idle(3);
    check_drops("resync");

    send_list('{8'h85, 8'hA0, 8'hC0, 8'hE5});
    send_list('{8'h86, 8'hA1, 8'hC7, 8'h01, 8'hE6});
    idle(3);
    check_drops("zero_and_oversize");
    check_drained("directed");

    rdy_mode = 0;
    idle(3);
    send_list(good);
    send_list('{8'h84, 8'hA0, 8'hC2, 8'h11, 8'h22, 8'h33});
    in_data  = 8'hE4;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_in_ready got %b expected 0", in_ready);
      end
    end
    rdy_mode = 1;
    send(8'hE4);
    check_drained("backpressure");

    rdy_mode = 0;
    idle(3);
    send_list(good);
    send_list('{8'h81, 8'hA1, 8'hC4});
    RST_N = 1'b0;
    #1;
    check_reset_outputs("mid_frame");
    expq.delete();
    model_reset();
    idle(2);
    RST_N = 1'b1;
    rdy_mode = 1;
    idle(1);
    send_list(good);
    idle(3);
    check_drops("after_reset");
    check_drained("after_reset");

    rdy_mode = 2;
    for (int f = 0; f < 300; f++) rand_frame();
    check_drained("random");
    check_drops("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
